// File: rtl/mem_access_master.sv
// mem_access_master: SAYEH data-RAM bus initiator with bounded rdy wait and automatic retry.
// Define MEM_WRITE_VERIFY_EN to read back every write and treat a mismatch as a failed attempt.
module mem_access_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int RETRIES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_nd,
  output logic              mem_we,
  input  logic              mem_rdy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ATT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [ATT_W-1:0] RTY = ATT_W'(RETRIES);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BACKOFF, RELEASE, FAIL} state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_rdata;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ATT_W-1:0]  r_att, w_att;
  logic              r_we, r_vfy, w_vfy;
  logic              r_resp_valid, r_resp_err, w_resp_valid, w_resp_err;
  logic              w_tmo, w_bad;

  assign w_tmo = r_cnt == TMO;
  assign w_bad = r_vfy && (mem_dout != r_wdata);

  // The counter is zero on entry to every state; ISSUE counts as the first cycle of an attempt.
  always_comb begin
    w_state      = r_state;
    w_cnt        = '0;
    w_att        = r_att;
    w_vfy        = r_vfy;
    w_rdata      = r_rdata;
    w_resp_valid = 1'b0;
    w_resp_err   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state = ISSUE;
          w_att   = '0;
          w_vfy   = 1'b0;
        end
      end
      ISSUE, WAIT: begin
        if (mem_rdy && !w_bad) begin
          w_state = RELEASE;
          w_rdata = r_we ? r_rdata : mem_dout;
        end else if (mem_rdy || (r_state == WAIT && w_tmo)) begin
          w_state = (r_att == RTY) ? FAIL : BACKOFF;
          w_vfy   = 1'b0;
        end else begin
          w_state = WAIT;
          w_cnt   = r_cnt + 1'b1;
        end
      end
      BACKOFF: begin
        if (!mem_rdy) begin
          w_state = ISSUE;
          w_att   = r_att + 1'b1;
        end else if (w_tmo) w_state = FAIL;
        else w_cnt = r_cnt + 1'b1;
      end
      RELEASE: begin
        if (!mem_rdy) begin
`ifdef MEM_WRITE_VERIFY_EN
          if (r_we && !r_vfy) begin
            w_state = ISSUE;
            w_vfy   = 1'b1;
          end else
`endif
          begin
            w_state      = IDLE;
            w_resp_valid = 1'b1;
          end
        end else if (w_tmo) w_state = FAIL;
        else w_cnt = r_cnt + 1'b1;
      end
      FAIL: begin
        w_state      = IDLE;
        w_resp_valid = 1'b1;
        w_resp_err   = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_att        <= '0;
      r_we         <= 1'b0;
      r_vfy        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_att        <= w_att;
      r_vfy        <= w_vfy;
      r_rdata      <= w_rdata;
      r_resp_valid <= w_resp_valid;
      r_resp_err   <= w_resp_err;
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
      end
    end
  end

  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_din    = r_wdata;
  assign mem_nd     = (r_state == ISSUE) || (r_state == WAIT);
  assign mem_we     = mem_nd && r_we && !r_vfy;
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed and random transactions against a negedge RAM model with fault injection.
module tb_mem_access_master;
  localparam int AW = 10, DW = 16, T = 15, R = 2;
`ifdef MEM_WRITE_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif
  localparam int WLAT = VFY ? 4 : 2;
  localparam int WISS = VFY ? 2 : 1;
  localparam int DEAD_LAT = (R + 1) * (T + 1) + R + 1;
  localparam int IGN_LAT = (T + 1) + 1 + 2;

  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_nd, mem_we, mem_rdy;
  logic [DW-1:0] resp_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] last_rd = '0;
  logic dead = 0, stuck = 0, ram_pnd = 0, ram_ign = 0;
  int ign_below = 0, ram_iss = 0;

  mem_access_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .RETRIES(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_nd(mem_nd), .mem_we(mem_we), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  // RAM: acts on nd at negedge; can be silent, skip chosen attempts, or read bit 0 of 0x020 as 1.
  always @(negedge clk) begin
    logic ig;
    ig = (mem_nd && !ram_pnd) ? (ram_iss < ign_below) : ram_ign;
    if (mem_nd && !ram_pnd) ram_iss <= ram_iss + 1;
    ram_pnd <= mem_nd;
    ram_ign <= ig;
    if (mem_nd && !dead && !ig) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_rdy  <= 1'b1;
      mem_dout <= ram[mem_addr] | {15'd0, stuck && mem_addr == 10'h020};
    end else begin
      mem_rdy  <= 1'b0;
      mem_dout <= 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int e_lat, input logic e_err, input int e_iss, input int e_wec);
    int lat, iss, wec, badwe, busy;
    logic pnd, rdy_at_resp;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0; iss = 0; wec = 0; badwe = 0; busy = 0; pnd = 0;
    forever begin
      iss += int'(mem_nd && !pnd);
      pnd = mem_nd;
      wec += int'(mem_we);
      badwe += int'(mem_we && !mem_nd);
      if (resp_valid || lat >= 300) break;
      busy += int'(req_ready);
      @(posedge clk); #1;
      lat++;
    end
    rdy_at_resp = req_ready;
    if (we && !dead) ref_mem[a] = d;
    if (!we && !e_err) last_rd = ref_mem[a];
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".err"}, resp_err, e_err);
    chk({tag, ".rdata"}, resp_rdata, last_rd);
    chk({tag, ".issues"}, iss, e_iss);
    chk({tag, ".we_cycles"}, wec, e_wec);
    chk({tag, ".we_without_nd"}, badwe, 0);
    chk({tag, ".ready_while_busy"}, busy, 0);
    chk({tag, ".ready_at_resp"}, rdy_at_resp, 1);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, resp_valid, 0);
  endtask

  initial begin
    int quiet;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 1024; i++) begin
      d = DW'($urandom);
      ram[i] = d;
      ref_mem[i] = d;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", req_ready, 1);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.nd", mem_nd, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.din", mem_din, 0);
    @(negedge clk); rst = 0;

    run("wr_beef", 1, 10'h005, 16'hBEEF, WLAT, 0, WISS, 1);
    run("rd_beef", 0, 10'h005, 16'h0000, 2, 0, 1, 0);
    chk("ram_beef", ram[10'h005], 16'hBEEF);

    ram[10'h3FF] = 16'h1234; ref_mem[10'h3FF] = 16'h1234;
    run("rd_3ff", 0, 10'h3FF, 16'h0000, 2, 0, 1, 0);

    dead = 1;
    run("dead", 0, 10'h100, 16'h0000, DEAD_LAT, 1, R + 1, 0);
    dead = 0;

    ign_below = ram_iss + 1;
    ram[10'h3FF] = 16'hA5C3; ref_mem[10'h3FF] = 16'hA5C3;
    run("ignore1", 0, 10'h3FF, 16'h0000, IGN_LAT, 0, 2, 0);

    dead = 1;
    @(negedge clk); req_valid = 1; req_we = 0; req_addr = 10'h010;
    @(posedge clk); #1; req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.nd_before", mem_nd, 1);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("mid.nd", mem_nd, 0);
    chk("mid.ready", req_ready, 1);
    chk("mid.resp_valid", resp_valid, 0);
    chk("mid.rdata", resp_rdata, 0);
    @(negedge clk); rst = 0; dead = 0; last_rd = '0;
    quiet = 0;
    repeat (4) begin
      @(posedge clk); #1;
      quiet += int'(resp_valid || mem_nd);
    end
    chk("mid.quiet", quiet, 0);
    run("mid.rd_010", 0, 10'h010, 16'h0000, 2, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 63));
      d = DW'($urandom);
      run("rnd", w, a, d, w ? WLAT : 2, 0, w ? WISS : 1, w ? 1 : 0);
    end

    stuck = 1;
    if (VFY != 0) run("stuck_w0", 1, 10'h020, 16'h0000, 4 * (R + 1), 1, 2 * (R + 1), R + 1);
    else run("stuck_w0", 1, 10'h020, 16'h0000, 2, 0, 1, 1);
    run("stuck_w1", 1, 10'h020, 16'h0001, WLAT, 0, WISS, 1);
    stuck = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
